// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: serial-to-parallel slot demux; slot k of each frame lands on out_data[k].
// Define TDM_PARITY_EN to add a ninth even-parity slot that must check before the word is released.
module tdm_demux_1x8 #(
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       frame_start,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       frame_err,
    output logic [2:0] slot,
    output logic       busy
);

    localparam logic [7:0] TMO_LIMIT = 8'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1
`ifdef TDM_PARITY_EN
        ,
        PAR     = 2'd2
`endif
    } state_t;

    state_t     state;
    logic [7:0] shift;
    logic [7:0] tmo;
    logic       resync;
    logic       beat;
    logic       expired;

    assign resync  = in_valid && frame_start;
    assign beat    = in_valid && !frame_start;
    assign expired = (tmo + 8'd1) == TMO_LIMIT;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= 8'h00;
            tmo       <= 8'h00;
            slot      <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    tmo <= 8'h00;
                    if (resync) begin
                        shift <= {7'd0, in_bit};
                        slot  <= 3'd1;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (resync) begin
                        // Restart on the marked beat; the partial frame is dropped.
                        frame_err <= 1'b1;
                        shift     <= {7'd0, in_bit};
                        slot      <= 3'd1;
                        tmo       <= 8'h00;
                    end else if (beat) begin
                        shift[slot] <= in_bit;
                        tmo         <= 8'h00;
                        if (slot == 3'd7) begin
`ifdef TDM_PARITY_EN
                            state <= PAR;
`else
                            out_data  <= {in_bit, shift[6:0]};
                            out_valid <= 1'b1;
                            slot      <= 3'd0;
                            state     <= IDLE;
`endif
                        end else begin
                            slot <= slot + 3'd1;
                        end
                    end else if (expired) begin
                        frame_err <= 1'b1;
                        tmo       <= 8'h00;
                        slot      <= 3'd0;
                        state     <= IDLE;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
`ifdef TDM_PARITY_EN
                PAR: begin
                    if (resync) begin
                        frame_err <= 1'b1;
                        shift     <= {7'd0, in_bit};
                        slot      <= 3'd1;
                        tmo       <= 8'h00;
                        state     <= COLLECT;
                    end else if (beat) begin
                        // Even parity over data plus parity bit.
                        if ((^shift) == in_bit) begin
                            out_data  <= shift;
                            out_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        tmo   <= 8'h00;
                        slot  <= 3'd0;
                        state <= IDLE;
                    end else if (expired) begin
                        frame_err <= 1'b1;
                        tmo       <= 8'h00;
                        slot      <= 3'd0;
                        state     <= IDLE;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
`endif
                default: begin
                    slot  <= 3'd0;
                    tmo   <= 8'h00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tdm_demux_1x8.md
# tdm_demux_1x8

Time-division demultiplexer that receives one serial bit per valid beat on a single line and distributes eight consecutive slots into an 8-bit parallel word. It is the receive end of our 8:1 slot-select multiplexing: slot k of a frame lands on out_data[k]. It includes frame-start alignment, an idle timeout and an optional parity slot. It sits between the serial link pins and the parallel register logic.

## Interface
- IDLE_TIMEOUT, 15: consecutive in_valid-low cycles tolerated mid-frame before abort; range 1–255; 8-bit counter.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, synchronous, active-high.
- in_bit  input  1  serial slot data, sampled only when in_valid=1.
- in_valid  input  1  beat qualifier; one slot per cycle with in_valid=1.
- frame_start  input  1  marks the current beat as slot 0; only meaningful with in_valid=1.
- out_data  output  8  last completed frame; slot k maps to bit k.
- out_valid  output  1  one-cycle pulse when out_data updates.
- frame_err  output  1  one-cycle pulse on resync, timeout or parity failure.
- slot  output  3  index of the next expected slot (0 in IDLE).
- busy  output  1  high while a frame is partially collected.

## Operation
- States: IDLE, COLLECT and PAR. PAR exists only with the parity macro.
- Reset: state=IDLE; out_data=8'h00; out_valid=0; frame_err=0; slot=0; busy=0; timeout counter=0.
- IDLE:
  - in_valid=1 with frame_start=1: write in_bit to shift bit 0; slot←1; go to COLLECT.
  - in_valid=1 with frame_start=0: beat ignored; no error.
- COLLECT, per beat with in_valid=1 and frame_start=0:
  - Store in_bit at index slot; slot increments; timeout counter clears.
  - Beat at slot=7 without parity: out_data←assembled word; out_valid pulses; go to IDLE; slot←0.
- COLLECT, beat with in_valid=1 and frame_start=1 (resync):
  - frame_err pulses; partial frame discarded.
  - The beat becomes slot 0 of a new frame; slot←1; stay in COLLECT.
- COLLECT, in_valid=0: timeout counter increments. When it reaches IDLE_TIMEOUT: frame_err pulses; partial frame discarded; go to IDLE; slot←0; out_data unchanged.
- out_data holds its value until the next successful frame. Error paths never modify out_data.
- busy=1 exactly when state≠IDLE.

## Timing
- Latency: out_valid and the new out_data appear in the cycle after the clock edge that samples the final slot (slot 7, or the parity slot).
- Back-to-back frames need no bubble. The next beat after the final slot may carry frame_start=1 and is accepted as slot 0.
- frame_err is registered: it pulses in the cycle after the offending edge. out_valid and frame_err are never high together.
- Timeout boundary: abort happens on the edge where the counter equals IDLE_TIMEOUT. With the default of 15, the 15th consecutive idle cycle aborts; a beat arriving on the 14th idle cycle continues the frame.
- rst asserted mid-frame: everything returns to reset values on that edge, including out_data, and no pulse is produced. If in_valid=1 during rst, the beat is dropped.

## Configuration
- TDM_PARITY_EN defined:
  - Frame length is 9 beats.
  - After the slot-7 beat the FSM enters PAR, with slot held at 7 and busy=1.
  - The next beat is an even-parity bit: the XOR of the 8 data bits and the parity bit must be 0.
  - Parity match: out_data updates and out_valid pulses.
  - Parity mismatch: frame_err pulses and out_data is unchanged.
  - Resync and timeout rules apply in PAR exactly as in COLLECT.
- TDM_PARITY_EN undefined: PAR and the parity logic are absent; frame length is 8 beats.

## Test plan
- Basic frame: after rst, send 8 contiguous beats with bits 1,0,1,1,0,0,1,0 and frame_start on the first beat. Expect out_data=8'h4D, with out_valid pulsing 1 cycle after the 8th beat.
- Back-to-back: send frames 8'hA5 and then 8'h3C with no gap. Expect two out_valid pulses 8 cycles apart, carrying the correct words, and frame_err=0.
- Resync: 4 beats, then a frame_start beat followed by 7 beats encoding 8'hFF. Expect one frame_err pulse, then out_data=8'hFF, with out_valid only once.
- Timeout: IDLE_TIMEOUT=15, 3 beats, then in_valid=0 for 15 cycles. Expect frame_err, busy→0, and out_data still at its previous value. Repeat with a 14-cycle gap and expect the frame to complete.
- Reset mid-frame: assert rst after 5 beats. Expect all outputs 0 with no pulses, and the next full frame decoded correctly.
- Parity (TDM_PARITY_EN): 8'h4D with parity bit 0 → out_valid. Same data with parity bit 1 → frame_err, out_data unchanged.
